// File: rtl/automatic_washing_machine_pkg.sv
// Shared types for the washing machine programme controller.
package automatic_washing_machine_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      CHECK_DOOR    = 3'd0,
      FILL_WATER    = 3'd1,
      ADD_DETERGENT = 3'd2,
      CYCLE         = 3'd3,
      DRAIN_WATER   = 3'd4,
      SPIN          = 3'd5,
      DONE          = 3'd6
   } state_t;

endpackage

// File: rtl/automatic_washing_machine.sv
// Moore controller for one wash programme: fill, soap wash, drain, rinse pass, spin.
module automatic_washing_machine
   import automatic_washing_machine_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic door_close,
   input  logic start,
   input  logic filled,
   input  logic detergent_added,
   input  logic cycle_timeout,
   input  logic drained,
   input  logic spin_timeout,
   output logic door_lock,
   output logic motor_on,
   output logic fill_value_on,
   output logic drain_value_on,
   output logic done,
   output logic soap_wash,
   output logic water_wash
);

   state_t r_state;
   state_t w_next_state;
   logic   r_soap_wash;
   logic   r_water_wash;
   logic   w_set_soap;
   logic   w_set_water;
   logic   w_clr_flags;

   // State register and phase flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= CHECK_DOOR;
         r_soap_wash  <= 1'b0;
         r_water_wash <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_clr_flags) begin
            r_soap_wash  <= 1'b0;
            r_water_wash <= 1'b0;
         end else begin
            if (w_set_soap)  r_soap_wash  <= 1'b1;
            if (w_set_water) r_water_wash <= 1'b1;
         end
      end
   end

   // Next state: each state looks only at its own exit input
   always_comb begin
      w_next_state = r_state;
      w_set_soap   = 1'b0;
      w_set_water  = 1'b0;
      w_clr_flags  = 1'b0;
      case (r_state)
         CHECK_DOOR: begin
            if (start && door_close) w_next_state = FILL_WATER;
         end
         FILL_WATER: begin
            if (filled) w_next_state = r_soap_wash ? CYCLE : ADD_DETERGENT;
         end
         ADD_DETERGENT: begin
            if (detergent_added) begin
               w_next_state = CYCLE;
               w_set_soap   = 1'b1;
            end
         end
         CYCLE: begin
            if (cycle_timeout) w_next_state = DRAIN_WATER;
         end
         DRAIN_WATER: begin
            if (drained) begin
               if (!r_water_wash) begin
                  w_next_state = FILL_WATER;
                  w_set_water  = 1'b1;
               end else begin
                  w_next_state = SPIN;
               end
            end
         end
         SPIN: begin
            if (spin_timeout) w_next_state = DONE;
         end
         DONE: begin
            w_next_state = CHECK_DOOR;
            w_clr_flags  = 1'b1;
         end
         default: w_next_state = CHECK_DOOR;
      endcase
   end

   // Actuator decode straight from the state register
   always_comb begin
      door_lock      = 1'b0;
      motor_on       = 1'b0;
      fill_value_on  = 1'b0;
      drain_value_on = 1'b0;
      done           = 1'b0;
      case (r_state)
         FILL_WATER: begin
            door_lock     = 1'b1;
            fill_value_on = 1'b1;
         end
         ADD_DETERGENT: door_lock = 1'b1;
         CYCLE: begin
            door_lock = 1'b1;
            motor_on  = 1'b1;
         end
         DRAIN_WATER: begin
            door_lock      = 1'b1;
            drain_value_on = 1'b1;
         end
         SPIN: begin
            door_lock      = 1'b1;
            motor_on       = 1'b1;
            drain_value_on = 1'b1;
         end
         DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign soap_wash  = r_soap_wash;
   assign water_wash = r_water_wash;

endmodule

// File: tb/tb_automatic_washing_machine.sv
// Directed bench for the washing machine controller; states are identified by their output pattern.
module tb_automatic_washing_machine;

   logic clk = 1'b0;
   logic reset;
   logic door_close, start, filled, detergent_added, cycle_timeout, drained, spin_timeout;
   logic door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash;
   logic [6:0] obs;

   int n_checks = 0;
   int n_fail   = 0;

   // {door_lock, motor_on, fill, drain, done, soap_wash, water_wash}
   localparam logic [6:0] O_CHECK = 7'b0000000;
   localparam logic [6:0] O_FILL  = 7'b1010000;
   localparam logic [6:0] O_ADD   = 7'b1000000;
   localparam logic [6:0] O_CYCLE = 7'b1100000;
   localparam logic [6:0] O_DRAIN = 7'b1001000;
   localparam logic [6:0] O_SPIN  = 7'b1101000;
   localparam logic [6:0] O_DONE  = 7'b0000100;
   localparam logic [6:0] F_S     = 7'b0000010;
   localparam logic [6:0] F_SW    = 7'b0000011;

   automatic_washing_machine dut (
      .clk             (clk),
      .reset           (reset),
      .door_close      (door_close),
      .start           (start),
      .filled          (filled),
      .detergent_added (detergent_added),
      .cycle_timeout   (cycle_timeout),
      .drained         (drained),
      .spin_timeout    (spin_timeout),
      .door_lock       (door_lock),
      .motor_on        (motor_on),
      .fill_value_on   (fill_value_on),
      .drain_value_on  (drain_value_on),
      .done            (done),
      .soap_wash       (soap_wash),
      .water_wash      (water_wash)
   );

   always #5 clk = ~clk;

   assign obs = {door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash};

   task automatic check(input string tag, input logic [6:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic v);
      door_close = v; start = v; filled = v; detergent_added = v;
      cycle_timeout = v; drained = v; spin_timeout = v;
   endtask

   initial begin
      // Reset held with start request pending
      reset = 1'b0;
      set_all(1'b0);
      start = 1'b1; door_close = 1'b1;
      #1;
      check("rst_async", O_CHECK);
      step(); step();
      check("rst_hold", O_CHECK);
      reset = 1'b1;
      step();
      check("rst_release_fill", O_FILL);

      // Door open blocks start
      reset = 1'b0; #1; reset = 1'b1;
      door_close = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("door_open_wait", O_CHECK);
      end
      door_close = 1'b1;
      step();
      check("door_closed_fill", O_FILL);

      // Full programme with every input high
      reset = 1'b0; #1;
      check("rst_mid_fill", O_CHECK);
      set_all(1'b1);
      reset = 1'b1;
      step(); check("seq1_fill",   O_FILL);
      step(); check("seq2_add",    O_ADD);
      step(); check("seq3_cycle",  O_CYCLE | F_S);
      step(); check("seq4_drain",  O_DRAIN | F_S);
      step(); check("seq5_fill2",  O_FILL  | F_SW);
      step(); check("seq6_cycle2", O_CYCLE | F_SW);
      step(); check("seq7_drain2", O_DRAIN | F_SW);
      step(); check("seq8_spin",   O_SPIN  | F_SW);
      step(); check("seq9_done",   O_DONE  | F_SW);
      step(); check("seq10_check", O_CHECK);
      step(); check("seq11_restart", O_FILL);

      // Foreign inputs ignored while filling
      reset = 1'b0; #1; reset = 1'b1;
      set_all(1'b0);
      start = 1'b1; door_close = 1'b1;
      step(); check("fill_enter", O_FILL);
      start = 1'b0; detergent_added = 1'b1;
      cycle_timeout = 1'b1; drained = 1'b1; spin_timeout = 1'b1;
      step(); check("fill_ignore_a", O_FILL);
      step(); check("fill_ignore_b", O_FILL);
      filled = 1'b1; cycle_timeout = 1'b0;
      step(); check("fill_to_add", O_ADD);
      step(); check("add_to_cycle", O_CYCLE | F_S);

      // Door sensor drop during wash is ignored
      door_close = 1'b0;
      step(); check("cycle_door_drop", O_CYCLE | F_S);
      cycle_timeout = 1'b1;
      step(); check("cycle_to_drain", O_DRAIN | F_S);

      // Rinse pass then stall in SPIN
      spin_timeout = 1'b0;
      step(); check("rinse_fill", O_FILL  | F_SW);
      step(); check("rinse_cycle", O_CYCLE | F_SW);
      step(); check("rinse_drain", O_DRAIN | F_SW);
      step(); check("spin_enter", O_SPIN  | F_SW);
      step(); check("spin_hold",  O_SPIN  | F_SW);

      // Asynchronous abort between edges
      #2;
      reset = 1'b0;
      #1;
      check("spin_async_abort", O_CHECK);
      step(); check("abort_hold", O_CHECK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
